// File: rtl/fifo_arb_pkg.sv
// Types, constants and parameter defaults for the FIFO write arbiter.
`timescale 1ns/1ps
package fifo_arb_pkg;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH    = 16;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by every block that writes the common FIFO.
`timescale 1ns/1ps
package fifo_pkg;
  localparam int DATA_WIDTH = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: combinational rotating find-first; returns i_start when nothing is valid.
`timescale 1ns/1ps
module rr_picker #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_start,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] w_pos [N];
  logic [N-1:0]  w_rot;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign w_pos[gi] = IW'((int'(i_start) + gi) % N);
    assign w_rot[gi] = i_valid[w_pos[gi]];
  end

  // Scan downward so the lowest rotated offset is the last (winning) assignment.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_found = 1'b1;
        o_idx   = w_pos[j];
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ writers into one FIFO.
// Optional per-requester word counters are built when FIFO_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module fifo_wr_arbiter
  import fifo_pkg::*;
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic                                 fifo_full,
  output logic                                 fifo_wr_en,
  output logic [DATA_WIDTH-1:0]                fifo_wr_data,
  output logic [IDX_W-1:0]                     grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic                                 stats_clr,
  output logic [NUM_REQ-1:0][STAT_WIDTH-1:0]   grant_cnt
`endif
);
  arb_state_e       r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [CNT_W-1:0] r_burst_cnt;

  logic             w_found;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_sel;
  logic             w_sel_valid;
  logic             w_xfer;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [IDX_W-1:0] w_sel_next;
  logic [IDX_W-1:0] w_owner_next;

  rr_picker #(.N(NUM_REQ)) u_picker (
    .i_valid (req_valid),
    .i_start (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  assign w_sel        = (r_state == ST_IDLE) ? w_pick : r_owner;
  assign w_sel_valid  = (r_state == ST_IDLE) ? w_found : req_valid[r_owner];
  // rst_n gates the accept path so nothing is written while reset is held.
  assign w_xfer       = rst_n && !fifo_full && w_sel_valid;
  assign w_cnt_inc    = r_burst_cnt + 1'b1;
  assign w_sel_next   = IDX_W'(wrap_inc(32'(w_sel), NUM_REQ));
  assign w_owner_next = IDX_W'(wrap_inc(32'(r_owner), NUM_REQ));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = (w_sel == IDX_W'(gi)) && w_xfer;
  end

  assign fifo_wr_en   = |(req_valid & req_ready);
  assign fifo_wr_data = req_data[w_sel];
  assign grant_id     = w_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
    end else if (!fifo_full) begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            if (MAX_BURST > 1) begin
              r_state     <= ST_LOCKED;
              r_owner     <= w_sel;
              r_burst_cnt <= CNT_W'(1);
            end else begin
              r_rr_ptr <= w_sel_next;
            end
          end
        end
        ST_LOCKED: begin
          if (w_xfer) begin
            r_burst_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_W'(MAX_BURST)) begin
              r_state     <= ST_IDLE;
              r_rr_ptr    <= w_owner_next;
              r_burst_cnt <= '0;
            end
          end else begin
            // Owner went quiet: this cycle is the bubble, release the lock.
            r_state     <= ST_IDLE;
            r_rr_ptr    <= w_owner_next;
            r_burst_cnt <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    logic [STAT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_cnt <= '0;
      else if (stats_clr)
        r_cnt <= '0;
      else if (req_valid[gi] && req_ready[gi] && (r_cnt != '1))
        r_cnt <= r_cnt + 1'b1;
    end
    assign grant_cnt[gi] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4); the stats test
// runs only when FIFO_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic [3:0]                      req_valid = '0;
  logic [3:0][DATA_WIDTH-1:0]      req_data;
  logic [3:0]                      req_ready;
  logic                            fifo_full = 1'b0;
  logic                            fifo_wr_en;
  logic [DATA_WIDTH-1:0]           fifo_wr_data;
  logic [1:0]                      grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic                            stats_clr = 1'b0;
  logic [3:0][15:0]                grant_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .grant_cnt    (grant_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_of(input int r);
    return 8'(8'h05 + 16 * r);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Checks one cycle's outputs; called after inputs for the cycle are applied.
  task automatic expect_cycle(input string tag, input logic en, input int gid);
    logic [3:0] rdy;
    #2;
    rdy = en ? 4'(1 << gid) : 4'b0000;
    $display("xact %s: wr_en=%0b grant=%0d data=%02h ready=%04b", tag, fifo_wr_en, grant_id, fifo_wr_data, req_ready);
    chk({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(en));
    chk({tag, ".grant"}, 32'(grant_id), 32'(gid));
    chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
    if (en) chk({tag, ".data"}, 32'(fifo_wr_data), 32'(word_of(gid)));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    fifo_full = 1'b0;
    #1;
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst.grant", 32'(grant_id), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t3_full [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
    logic       t3_en   [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
    int         t3_gid  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [3:0] t4_vld  [4] = '{4'b1010, 4'b1010, 4'b1000, 4'b1000};
    logic       t4_en   [4] = '{1, 1, 0, 1};
    int         t4_gid  [4] = '{1, 1, 1, 3};

    for (int i = 0; i < 4; i++) req_data[i] = word_of(i);

    // Single requester, six words: burst of 4, IDLE regrant, 2 more, bubble.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      nxt();
      req_valid = 4'b0100;
      if (k == 4) begin
        req_valid = 4'b0000;
        #1;
        chk("t1.rr_ptr_after_burst", 32'(grant_id), 32'd3);
        req_valid = 4'b0100;
      end
      expect_cycle($sformatf("t1.w%0d", k), 1'b1, 2);
    end
    nxt();
    req_valid = 4'b0000;
    expect_cycle("t1.bubble", 1'b0, 2);
    nxt();
    expect_cycle("t1.idle", 1'b0, 3);

    // All requesters valid: bursts of 4 in round-robin order, no bubbles.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      nxt();
      req_valid = 4'b1111;
      expect_cycle($sformatf("t2.w%0d", k), 1'b1, (k / 4) % 4);
    end
    req_valid = 4'b0000;

    // FIFO full for 3 cycles at burst_cnt=2: burst freezes then completes.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      nxt();
      req_valid = 4'b0011;
      fifo_full = t3_full[k][0];
      expect_cycle($sformatf("t3.c%0d", k), t3_en[k], t3_gid[k]);
    end
    req_valid = 4'b0000;
    fifo_full = 1'b0;

    // Owner 1 stops after 2 words: one bubble, then req 3.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      nxt();
      req_valid = t4_vld[k];
      expect_cycle($sformatf("t4.c%0d", k), t4_en[k], t4_gid[k]);
    end
    req_valid = 4'b0000;

    // Reset mid-burst drops the lock immediately.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      nxt();
      req_valid = 4'b0100;
      expect_cycle($sformatf("t5.w%0d", k), 1'b1, 2);
    end
    nxt();
    rst_n = 1'b0;
    #1;
    chk("t5.rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("t5.rst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    #1;
    chk("t5.rr_ptr", 32'(grant_id), 32'd0);
    req_valid = 4'b0110;
    #1;
    chk("t5.idle_grant", 32'(grant_id), 32'd1);
    chk("t5.idle_wr_en", 32'(fifo_wr_en), 32'd1);
    req_valid = 4'b0000;

`ifdef FIFO_ARB_STATS_EN
    // 70000 words from req 0 saturate its counter; stats_clr beats the increment.
    do_reset();
    req_valid = 4'b0001;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("st.sat0", 32'(grant_cnt[0]), 32'd65535);
    chk("st.cnt1", 32'(grant_cnt[1]), 32'd0);
    stats_clr = 1'b1;
    nxt();
    stats_clr = 1'b0;
    chk("st.clr0", 32'(grant_cnt[0]), 32'd0);
    req_valid = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
